// File: rtl/pkg.sv
// Shared constants, opcode encoding, memory request payload and the ALU used by every core.
package pkg;

    localparam int unsigned NUM_CORES = 3;
    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned RES_W     = 16;
    localparam int unsigned OP_W      = 3;
    localparam int unsigned MEM_DEPTH = 1 << ADDR_W;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_MUL   = 3'd2,
        OP_AND   = 3'd3,
        OP_OR    = 3'd4,
        OP_XOR   = 3'd5,
        OP_LOAD  = 3'd6,
        OP_STORE = 3'd7
    } opcode_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_req_t;

    // Operands are widened first so ADD keeps its carry and SUB/MUL wrap at 16 bits.
    function automatic logic [RES_W-1:0] alu(input opcode_t op,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
        logic [RES_W-1:0] aw;
        logic [RES_W-1:0] bw;
        aw = RES_W'(a);
        bw = RES_W'(b);
        case (op)
            OP_ADD:  return aw + bw;
            OP_SUB:  return aw - bw;
            OP_MUL:  return aw * bw;
            OP_AND:  return aw & bw;
            OP_OR:   return aw | bw;
            OP_XOR:  return aw ^ bw;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/core_unit.sv
// One processing core: operand latch, ALU, and a request/grant port toward the shared memory.
module core_unit
    import pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              start_op,
    input  logic [OP_W-1:0]   op_sel,
    input  logic [ADDR_W-1:0] address_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              req_c,
    input  logic              grant,
    input  logic [DATA_W-1:0] rdata,
    output mem_req_t          mem_req,
    output logic              end_op,
    output logic [RES_W-1:0]  result
);

    typedef enum logic [1:0] {IDLE, EXEC, MEM_REQ, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] a_nxt;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] b_nxt;
    opcode_t           op_q;
    opcode_t           op_nxt;
    opcode_t           op_in;
    mem_req_t          mem_req_nxt;
    logic              end_op_nxt;
    logic [RES_W-1:0]  result_nxt;

    assign op_in = opcode_t'(op_sel);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            mem_req <= '0;
            end_op  <= 1'b0;
            result  <= '0;
        end else begin
            state   <= state_nxt;
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            op_q    <= op_nxt;
            mem_req <= mem_req_nxt;
            end_op  <= end_op_nxt;
            result  <= result_nxt;
        end
    end

    // Inputs are sampled only in IDLE; end_op is raised solely on the completing edge.
    always_comb begin
        state_nxt   = state;
        a_nxt       = a_q;
        b_nxt       = b_q;
        op_nxt      = op_q;
        mem_req_nxt = mem_req;
        end_op_nxt  = 1'b0;
        result_nxt  = result;
        req_c       = 1'b0;
        case (state)
            IDLE: begin
                if (start_op) begin
                    a_nxt             = a;
                    b_nxt             = b;
                    op_nxt            = op_in;
                    mem_req_nxt.write = (op_in == OP_STORE);
                    mem_req_nxt.addr  = address_in;
                    mem_req_nxt.data  = data_in;
                    state_nxt = (op_in == OP_LOAD || op_in == OP_STORE) ? MEM_REQ : EXEC;
                end
            end
            EXEC: begin
                result_nxt = alu(op_q, a_q, b_q);
                end_op_nxt = 1'b1;
                state_nxt  = DONE;
            end
            MEM_REQ: begin
                req_c = 1'b1;
                if (grant) begin
                    if (!mem_req.write) begin
                        result_nxt = RES_W'(rdata);
                    end
                    end_op_nxt = 1'b1;
                    state_nxt  = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/top.sv
// Three cores sharing one byte-wide memory through a round-robin arbiter (one access per cycle).
module top
    import pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CORES-1:0][DATA_W-1:0]   A,
    input  logic [NUM_CORES-1:0][DATA_W-1:0]   B,
    input  logic [NUM_CORES-1:0]               start_op,
    input  logic [NUM_CORES-1:0][OP_W-1:0]     op_sel,
    input  logic [NUM_CORES-1:0][ADDR_W-1:0]   address_in,
    input  logic [NUM_CORES-1:0][DATA_W-1:0]   data_in,
    output logic [NUM_CORES-1:0]               end_op,
    output logic [NUM_CORES-1:0][RES_W-1:0]    result
);

    localparam int unsigned PTR_W = $clog2(NUM_CORES);

    logic [NUM_CORES-1:0] req_c;
    logic [NUM_CORES-1:0] grant_c;
    mem_req_t             mem_req [NUM_CORES];
    mem_req_t             sel_c;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     ptr_nxt_c;
    logic [PTR_W-1:0]     idx_c;
    logic [DATA_W-1:0]    rdata_c;
    logic [DATA_W-1:0]    mem [MEM_DEPTH];

    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] p, input int unsigned k);
        return PTR_W'((32'(p) + k) % NUM_CORES);
    endfunction

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        core_unit u_core (
            .clk        (clk),
            .rst        (rst),
            .a          (A[i]),
            .b          (B[i]),
            .start_op   (start_op[i]),
            .op_sel     (op_sel[i]),
            .address_in (address_in[i]),
            .data_in    (data_in[i]),
            .req_c      (req_c[i]),
            .grant      (grant_c[i]),
            .rdata      (rdata_c),
            .mem_req    (mem_req[i]),
            .end_op     (end_op[i]),
            .result     (result[i])
        );
    end

    // Scan requesters starting at the pointer; the pointer then moves past the winner.
    always_comb begin
        grant_c   = '0;
        ptr_nxt_c = ptr;
        idx_c     = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            idx_c = rr_idx(ptr, k);
            if (grant_c == '0 && req_c[idx_c]) begin
                grant_c[idx_c] = 1'b1;
                ptr_nxt_c = (idx_c == PTR_W'(NUM_CORES - 1)) ? '0 : idx_c + 1'b1;
            end
        end
    end

    always_comb begin
        sel_c = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (grant_c[k]) begin
                sel_c = mem_req[k];
            end
        end
    end

    assign rdata_c = mem[sel_c.addr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt_c;
        end
    end

    // Memory contents survive reset; writes only happen on a granted STORE.
    always_ff @(posedge clk) begin
        if (grant_c != '0 && sel_c.write) begin
            mem[sel_c.addr] <= sel_c.data;
        end
    end

endmodule

// File: tb/tb_top.sv
// Bench for top: directed vector table, multi-cycle corner sequences, and random traffic vs a cycle model.
module tb_top;

    localparam int OP_ADD = 0, OP_SUB = 1, OP_MUL = 2, OP_AND = 3;
    localparam int OP_OR = 4, OP_XOR = 5, OP_LOAD = 6, OP_STORE = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0][7:0]  A;
    logic [2:0][7:0]  B;
    logic [2:0]       start_op;
    logic [2:0][2:0]  op_sel;
    logic [2:0][11:0] address_in;
    logic [2:0][7:0]  data_in;
    logic [2:0]       end_op;
    logic [2:0][15:0] result;

    top dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .B          (B),
        .start_op   (start_op),
        .op_sel     (op_sel),
        .address_in (address_in),
        .data_in    (data_in),
        .end_op     (end_op),
        .result     (result)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 idle, 1 computing, 2 waiting for memory, 3 completion cycle.
    int m_ph [3];
    int m_op [3];
    int m_a [3];
    int m_b [3];
    int m_addr [3];
    int m_data [3];
    int m_res [3];
    int m_end [3];
    int m_ptr;
    int m_mem [4096];

    typedef struct {
        int core;
        int op;
        int a;
        int b;
        int addr;
        int data;
        int exp;
    } vec_t;

    vec_t vecs [$];

    function automatic int ref_alu(input int op, input int a, input int b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return (a - b + 65536) % 65536;
            OP_MUL:  return a * b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_ph[c]  = 0;
            m_end[c] = 0;
            m_res[c] = 0;
        end
        m_ptr = 0;
    endtask

    task automatic model_step();
        int g;
        if (rst == 1'b0) begin
            model_reset();
            return;
        end
        g = -1;
        for (int k = 0; k < 3; k++) begin
            if (g < 0 && m_ph[(m_ptr + k) % 3] == 2) g = (m_ptr + k) % 3;
        end
        for (int c = 0; c < 3; c++) begin
            m_end[c] = 0;
            case (m_ph[c])
                0: if (start_op[c]) begin
                    m_op[c]   = int'(op_sel[c]);
                    m_a[c]    = int'(A[c]);
                    m_b[c]    = int'(B[c]);
                    m_addr[c] = int'(address_in[c]);
                    m_data[c] = int'(data_in[c]);
                    m_ph[c]   = (m_op[c] >= OP_LOAD) ? 2 : 1;
                end
                1: begin
                    m_res[c] = ref_alu(m_op[c], m_a[c], m_b[c]);
                    m_end[c] = 1;
                    m_ph[c]  = 3;
                end
                2: if (c == g) begin
                    if (m_op[c] == OP_STORE) m_mem[m_addr[c]] = m_data[c];
                    else m_res[c] = m_mem[m_addr[c]];
                    m_end[c] = 1;
                    m_ph[c]  = 3;
                end
                default: m_ph[c] = 0;
            endcase
        end
        if (g >= 0) m_ptr = (g + 1) % 3;
    endtask

    // One clock: advance the model with the applied inputs, then compare every core.
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("end_op%0d", c), int'(end_op[c]), m_end[c]);
            check($sformatf("result%0d", c), int'(result[c]), m_res[c]);
        end
    endtask

    task automatic issue(input int c, input int op, input int a, input int b,
                         input int addr, input int data);
        op_sel[c]     = 3'(op);
        A[c]          = 8'(a);
        B[c]          = 8'(b);
        address_in[c] = 12'(addr);
        data_in[c]    = 8'(data);
        start_op[c]   = 1'b1;
    endtask

    task automatic run_op(input int c, input int op, input int a, input int b,
                          input int addr, input int data, output int res, output int lat);
        issue(c, op, a, b, addr, data);
        cycle();
        start_op[c] = 1'b0;
        lat = 1;
        while (end_op[c] !== 1'b1 && lat < 20) begin
            cycle();
            lat++;
        end
        res = int'(result[c]);
        cycle();
        check("end_op_one_cycle", int'(end_op[c]), 0);
    endtask

    initial begin
        int res;
        int lat;
        int pulses;

        rst = 1'b0;
        start_op = '0;
        A = '0;
        B = '0;
        op_sel = '0;
        address_in = '0;
        data_in = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_end_op", int'(end_op), 0);
        for (int c = 0; c < 3; c++) check("reset_result", int'(result[c]), 0);
        rst = 1'b1;
        cycle();

        vecs.push_back('{0, OP_STORE, 8'h00, 8'h00, 12'h011, 8'hFE, 16'h0000});
        vecs.push_back('{0, OP_LOAD,  8'h00, 8'h00, 12'h011, 8'h00, 16'h00FE});
        vecs.push_back('{1, OP_ADD,   8'hFF, 8'hFE, 12'h000, 8'h00, 16'h01FD});
        vecs.push_back('{1, OP_MUL,   8'hFF, 8'hFE, 12'h000, 8'h00, 16'hFD02});
        vecs.push_back('{1, OP_SUB,   8'h01, 8'h11, 12'h000, 8'h00, 16'hFFF0});
        vecs.push_back('{2, OP_AND,   8'hF0, 8'h3C, 12'h000, 8'h00, 16'h0030});
        vecs.push_back('{2, OP_OR,    8'hF0, 8'h3C, 12'h000, 8'h00, 16'h00FC});
        vecs.push_back('{2, OP_XOR,   8'hF0, 8'h3C, 12'h000, 8'h00, 16'h00CC});
        vecs.push_back('{2, OP_STORE, 8'h00, 8'h00, 12'hFFF, 8'h55, 16'h00CC});
        vecs.push_back('{2, OP_LOAD,  8'h00, 8'h00, 12'hFFF, 8'h00, 16'h0055});
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].core, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].addr, vecs[i].data, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, 2);
        end

        // Simultaneous stores from a fresh pointer complete in core order.
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        for (int c = 0; c < 3; c++) issue(c, OP_STORE, 0, 0, 12'h100 + c, 8'hA0 + c);
        cycle();
        start_op = '0;
        cycle();
        check("rr_order0", int'(end_op), 3'b001);
        cycle();
        check("rr_order1", int'(end_op), 3'b010);
        cycle();
        check("rr_order2", int'(end_op), 3'b100);
        cycle();
        for (int c = 0; c < 3; c++) begin
            run_op(c, OP_LOAD, 0, 0, 12'h100 + c, 0, res, lat);
            check($sformatf("rr_load%0d", c), res, 16'h00A0 + c);
        end

        // ALU core finishes on time while two loads contend.
        issue(0, OP_ADD, 8'h12, 8'h34, 0, 0);
        issue(1, OP_LOAD, 0, 0, 12'h101, 0);
        issue(2, OP_LOAD, 0, 0, 12'h100, 0);
        cycle();
        start_op = '0;
        cycle();
        check("mix_end_a", int'(end_op), 3'b011);
        check("mix_add", int'(result[0]), 16'h0046);
        check("mix_ld1", int'(result[1]), 16'h00A1);
        cycle();
        check("mix_end_b", int'(end_op), 3'b100);
        check("mix_ld2", int'(result[2]), 16'h00A0);
        cycle();

        // Held start_op: back-to-back ADDs.
        issue(0, OP_ADD, 8'h7F, 8'h81, 0, 0);
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            cycle();
            if (end_op[0] === 1'b1) pulses++;
            if (i >= 1) check("held_sum", int'(result[0]), 16'h0100);
        end
        start_op = '0;
        check("held_pulses", pulses, 3);
        cycle();
        cycle();

        // Reset while a STORE is waiting for memory: no write, outputs cleared at once.
        run_op(0, OP_STORE, 0, 0, 12'h040, 8'h5A, res, lat);
        issue(0, OP_STORE, 0, 0, 12'h040, 8'hC3);
        issue(1, OP_ADD, 1, 2, 0, 0);
        cycle();
        start_op = '0;
        rst = 1'b0;
        #1;
        check("async_end_op", int'(end_op), 0);
        check("async_result0", int'(result[0]), 0);
        check("async_result1", int'(result[1]), 0);
        model_reset();
        @(negedge clk);
        cycle();
        rst = 1'b1;
        cycle();
        run_op(0, OP_LOAD, 0, 0, 12'h040, 0, res, lat);
        check("reset_no_write", res, 16'h005A);
        check("reset_load_latency", lat, 2);

        // Random traffic over a pre-initialised address window.
        for (int i = 0; i < 32; i++) run_op(i % 3, OP_STORE, 0, 0, 12'h200 + i, $urandom_range(0, 255), res, lat);
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < 3; c++) begin
                start_op[c]   = ($urandom_range(0, 3) != 0);
                op_sel[c]     = 3'($urandom_range(0, 7));
                A[c]          = 8'($urandom_range(0, 255));
                B[c]          = 8'($urandom_range(0, 255));
                address_in[c] = 12'(12'h200 + $urandom_range(0, 31));
                data_in[c]    = 8'($urandom_range(0, 255));
            end
            cycle();
        end
        start_op = '0;
        for (int i = 0; i < 4; i++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameters SHALL be taken from package pkg: NUM_CORES = 3, cores 0..2; ADDR_W = 12; DATA_W = 8; RES_W = 16.
REQ-002 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 A[2:0]  input  8 each  operand A per core.
REQ-005 B[2:0]  input  8 each  operand B per core.
REQ-006 start_op[2:0]  input  1 each  operation request per core.
REQ-007 op_sel[2:0]  input  opcode each  operation select per core.
REQ-008 address_in[2:0]  input  12 each  shared-memory byte address per core.
REQ-009 data_in[2:0]  input  8 each  STORE write data per core.
REQ-010 end_op[2:0]  output  1 each  one-cycle completion pulse per core.
REQ-011 result[2:0]  output  16 each  registered operation result per core.

Function
REQ-012 Opcode encoding SHALL be 3-bit: ADD=0, SUB=1, MUL=2, AND=3, OR=4, XOR=5, LOAD=6, STORE=7.
REQ-013 Memory: one shared 4096x8 array, one access per cycle (read or write); contents not cleared by reset.
REQ-014 Each core SHALL run an independent FSM with states IDLE, EXEC, MEM_REQ, DONE.
REQ-015 IDLE, start_op=1 at an edge: latch A, B, op_sel, address_in, data_in; go to EXEC for ALU opcodes, MEM_REQ for LOAD/STORE; inputs after latching are ignored until IDLE.
REQ-016 EXEC: at next edge write ALU result to result, set end_op=1, go to DONE (ALU latency = 2 edges from acceptance to end_op high).
REQ-017 ALU: ADD = zero-extended 9-bit sum; SUB = (A-B) mod 2^16; MUL = full 16-bit unsigned product; AND/OR/XOR = bitwise, zero-extended to 16 bits.
REQ-018 MEM_REQ: core asserts an internal request; on the edge it is granted, STORE writes latched data to latched address; LOAD performs a synchronous read.
REQ-019 Grant edge: STORE sets end_op=1, result unchanged; LOAD sets result={8'h00, mem[addr]} and end_op=1; go to DONE.
REQ-020 DONE: at next edge clear end_op, go to IDLE; end_op is high exactly one cycle per operation.
REQ-021 start_op held high SHALL re-accept in IDLE, giving back-to-back operations (ALU end_op every 3rd cycle).
REQ-022 Arbiter: round-robin over the 3 requests, at most one grant per cycle, priority pointer moves to the core after the granted one; no request waits more than 2 grant cycles.
REQ-023 Non-memory cores are never stalled by memory arbitration.
REQ-024 result SHALL hold its last value until the next completion of that core.

Reset
REQ-025 rst=0 SHALL immediately force all FSMs to IDLE, end_op=0, result=0, arbiter pointer=core 0, pending requests dropped with no memory write.
REQ-026 Operations in progress when reset asserts SHALL be discarded; after rst returns to 1, the first acceptance is the first edge with start_op=1.

Structure
REQ-027 pkg SHALL hold the opcode enum typedef and NUM_CORES, ADDR_W, DATA_W, RES_W constants.
REQ-028 One sub-module core_unit (FSM + ALU + request/grant port) SHALL be instantiated 3 times; the memory array and round-robin arbiter reside in top.

Verification
REQ-029 Core0 STORE 0xFE @0x011, then LOAD @0x011 -> LOAD result=0x00FE, each end_op high exactly one cycle.
REQ-030 Core1 ADD A=0xFF, B=0xFE -> result=0x01FD with end_op 2 edges after acceptance; MUL same operands -> 0xFD02; SUB A=0x01, B=0x11 -> 0xFFF0.
REQ-031 All 3 cores STORE same cycle to 0x100/0x101/0x102 data 0xA0/0xA1/0xA2 -> end_op order core0, core1, core2 on consecutive cycles; loads read back 0x00A0/0x00A1/0x00A2.
REQ-032 Core2 LOAD while core0 does ADD same cycle -> core0 end_op unaffected by arbitration, both results correct.
REQ-033 start_op held high on ADD for 9 cycles -> 3 end_op pulses, result constant at correct sum.
REQ-034 rst driven low while core0 STORE is in MEM_REQ -> end_op=0, result=0 immediately; later LOAD of that address shows old contents.
